// File: rtl/iq_stream_pkg.sv
// Shared definitions for the IQ interleaver and its matching deinterleaver.
// A complex pair is packed as {I, Q}: I occupies the upper DW bits of a 2*DW word.
package iq_stream_pkg;

  localparam int DW_DEF    = 18;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF    = 16;

  // Interleave phase, equal to the iq output. PH_START marks the pre-edge phase of a pair start.
  typedef enum logic {
    PH_START = 1'b0,
    PH_MID   = 1'b1
  } iq_phase_e;

endpackage

// File: rtl/iq_interleave_if.sv
// Complex-pair input stream of the interleaver.
// Handshake: a pair transfers on a rising clk edge when in_valid and in_ready are both high;
// the master holds in_i/in_q/in_valid stable until that edge, and in_ready never depends on in_valid.
interface iq_interleave_if #(
  parameter int DW = iq_stream_pkg::DW_DEF
);
  logic signed [DW-1:0] in_i;
  logic signed [DW-1:0] in_q;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_i, output in_q, output in_valid, input in_ready);
  modport slave  (input in_i, input in_q, input in_valid, output in_ready);
endinterface

// File: rtl/iq_pair_fifo.sv
// Power-of-two FIFO of packed complex pairs; flags decoded from registered occupancy.
module iq_pair_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_OCC  = (AW + 1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   occ_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o    = (occ_q == FULL_OCC);
  assign empty_o   = (occ_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + ONE_OCC;
        2'b01:   occ_q <= occ_q - ONE_OCC;
        default: occ_q <= occ_q;
      endcase
    end
  end
endmodule

// File: rtl/iq_interleave.sv
// Serialises buffered (I,Q) pairs onto one sample stream with a free-running iq phase flag:
// I is on x while iq=1, Q while iq=0; missed pairs emit zeros and count as underruns.
module iq_interleave
  import iq_stream_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  iq_interleave_if.slave       s,
  output logic                 iq,
  output logic signed [DW-1:0] x,
  output logic                 underrun,
  output logic [CW-1:0]        underrun_count
);
  iq_phase_e            phase_q, phase_d;
  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] hold_q, hold_d;
  logic                 underrun_q, underrun_d;
  logic [CW-1:0]        count_q, count_d;

  logic [2*DW-1:0]      rd_data;
  logic                 full;
  logic                 empty;
  logic                 pair_start;
  logic                 pop;

  assign pair_start = (phase_q == PH_START);
  assign pop        = pair_start & enable & ~empty;

  iq_pair_fifo #(
    .W     (2 * DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (s.in_valid),
    .wr_data_i ({s.in_i, s.in_q}),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  always_comb begin
    phase_d    = (phase_q == PH_START) ? PH_MID : PH_START;
    x_d        = x_q;
    hold_d     = hold_q;
    underrun_d = 1'b0;
    count_d    = count_q;
    if (pair_start) begin
      if (pop) begin
        x_d    = rd_data[2*DW-1:DW];
        hold_d = rd_data[DW-1:0];
      end else begin
        // Disabled or starved: emit a zero pair; only a starved enabled stream is an underrun.
        x_d    = '0;
        hold_d = '0;
        if (enable) begin
          underrun_d = 1'b1;
          if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
        end
      end
    end else begin
      x_d = hold_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= PH_START;
      x_q        <= '0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
      count_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      x_q        <= x_d;
      hold_q     <= hold_d;
      underrun_q <= underrun_d;
      count_q    <= count_d;
    end
  end

  assign s.in_ready     = ~full;
  assign iq             = phase_q;
  assign x              = x_q;
  assign underrun       = underrun_q;
  assign underrun_count = count_q;
endmodule

// File: tb/tb_iq_interleave.sv
// Directed bench for iq_interleave: vector table plus hand-written burst, disable and reset sequences.
module tb_iq_interleave;
  import iq_stream_pkg::*;

  localparam int DW = 18;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;
  logic en4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iq_interleave_if #(.DW(DW)) sif ();
  iq_interleave_if #(.DW(DW)) sif4 ();

  logic                 iq, iq4;
  logic signed [DW-1:0] x, x4;
  logic                 und, und4;
  logic [15:0]          cnt;
  logic [3:0]           cnt4;

  iq_interleave #(.DW(DW), .DEPTH(4), .CW(16)) dut (
    .clk (clk), .rst (rst), .enable (en), .s (sif.slave),
    .iq (iq), .x (x), .underrun (und), .underrun_count (cnt)
  );

  iq_interleave #(.DW(DW), .DEPTH(4), .CW(4)) dut4 (
    .clk (clk), .rst (rst), .enable (en4), .s (sif4.slave),
    .iq (iq4), .x (x4), .underrun (und4), .underrun_count (cnt4)
  );

  // ---------------- scoreboard ----------------
  int n_vec;
  int n_bad;
  logic [2*DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int i, input int q);
    sif.in_valid = v;
    sif.in_i     = DW'(i);
    sif.in_q     = DW'(q);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    drive(1'b0, 0, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_iq", iq, 0);
    chk("rst_x", x, 0);
    chk("rst_ready", sif.in_ready, 1);
    chk("rst_underrun", und, 0);
    chk("rst_count", cnt, 0);
    #1 rst = 1'b0;
  endtask

  // Drain with enable high, checking each popped pair as I then Q; zero pairs flagged as underrun are skipped.
  task automatic drain(input string tag);
    logic            pend;
    logic [2*DW-1:0] e;
    int              guard;
    pend  = 1'b0;
    e     = '0;
    guard = 0;
    en    = 1'b1;
    drive(1'b0, 0, 0);
    while ((exp_q.size() > 0 || pend) && guard < 40) begin
      step();
      guard++;
      if (iq == 1'b1) begin
        if (und) chk({tag, "_skip_x"}, x, 0);
        else begin
          e = exp_q.pop_front();
          chk({tag, "_i"}, x, $signed(e[2*DW-1:DW]));
          pend = 1'b1;
        end
      end else if (pend) begin
        chk({tag, "_q"}, x, $signed(e[DW-1:0]));
        pend = 1'b0;
      end
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic en;
    logic val;
    int   i;
    int   q;
    logic e_iq;
    int   e_x;
    logic e_rdy;
    logic e_und;
    int   e_cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int acc;
    int guard;
    logic pend;
    logic [2*DW-1:0] e;

    n_vec = 0;
    n_bad = 0;
    en4 = 1'b1;
    sif4.in_valid = 1'b0;
    sif4.in_i = '0;
    sif4.in_q = '0;

    //            en val    i      q    iq  x      rdy und cnt
    tbl[0]  = '{1'b1, 1'b0,     0,    0, 1'b1,     0, 1'b1, 1'b1, 1};
    tbl[1]  = '{1'b1, 1'b1, 20000,    0, 1'b0,     0, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b1, 1'b0,     0,    0, 1'b1, 20000, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b1, 1'b0,     0,    0, 1'b0,     0, 1'b1, 1'b0, 1};
    tbl[4]  = '{1'b1, 1'b1,    -5,    7, 1'b1,     0, 1'b1, 1'b1, 2};
    tbl[5]  = '{1'b1, 1'b0,     0,    0, 1'b0,     0, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b1, 1'b0,     0,    0, 1'b1,    -5, 1'b1, 1'b0, 2};
    tbl[7]  = '{1'b1, 1'b0,     0,    0, 1'b0,     7, 1'b1, 1'b0, 2};
    tbl[8]  = '{1'b0, 1'b0,     0,    0, 1'b1,     0, 1'b1, 1'b0, 2};
    tbl[9]  = '{1'b1, 1'b0,     0,    0, 1'b0,     0, 1'b1, 1'b0, 2};
    tbl[10] = '{1'b1, 1'b0,     0,    0, 1'b1,     0, 1'b1, 1'b1, 3};
    tbl[11] = '{1'b1, 1'b1,   300, -400, 1'b0,     0, 1'b1, 1'b0, 3};
    tbl[12] = '{1'b1, 1'b0,     0,    0, 1'b1,   300, 1'b1, 1'b0, 3};
    tbl[13] = '{1'b0, 1'b0,     0,    0, 1'b0,  -400, 1'b1, 1'b0, 3};
    tbl[14] = '{1'b0, 1'b0,     0,    0, 1'b1,     0, 1'b1, 1'b0, 3};

    // Starved stream: underrun every pair, 16-bit count climbs, 4-bit count saturates at 15.
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      chk("starve_iq", iq, n % 2);
      chk("starve_x", x, 0);
      chk("starve_underrun", und, n % 2);
      chk("starve_count", cnt, (n + 1) / 2);
      chk("sat_underrun", und4, n % 2);
      chk("sat_count", cnt4, ((n + 1) / 2 > 15) ? 15 : (n + 1) / 2);
    end
    chk("starve_count_20", cnt, 20);

    // Table: single pair, pair-start push race, disabled pair, enable dropped mid-pair.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      en = tbl[k].en;
      drive(tbl[k].val, tbl[k].i, tbl[k].q);
      step();
      chk($sformatf("tbl%0d_iq", k), iq, tbl[k].e_iq);
      chk($sformatf("tbl%0d_x", k), x, tbl[k].e_x);
      chk($sformatf("tbl%0d_ready", k), sif.in_ready, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_underrun", k), und, tbl[k].e_und);
      chk($sformatf("tbl%0d_count", k), cnt, tbl[k].e_cnt);
    end

    // Burst of 6 pairs: fill to full with enable low, then drain with continuous in_valid.
    do_reset();
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, (acc + 1) * 1000, -(acc + 1) * 1000);
      chk("burst_fill_ready", sif.in_ready, (acc < 4) ? 1 : 0);
      if (sif.in_ready) begin
        exp_q.push_back({sif.in_i, sif.in_q});
        acc++;
      end
      step();
    end
    chk("burst_buffered", acc, 4);
    en    = 1'b1;
    pend  = 1'b0;
    e     = '0;
    guard = 0;
    while ((acc < 6 || exp_q.size() > 0 || pend) && guard < 60) begin
      if (acc < 6) drive(1'b1, (acc + 1) * 1000, -(acc + 1) * 1000);
      else drive(1'b0, 0, 0);
      if (sif.in_valid && sif.in_ready) begin
        exp_q.push_back({sif.in_i, sif.in_q});
        acc++;
      end
      step();
      guard++;
      if (iq == 1'b1) begin
        if (exp_q.size() > 0) begin
          chk("burst_gap", und, 0);
          e = exp_q.pop_front();
          chk("burst_i", x, $signed(e[2*DW-1:DW]));
          pend = 1'b1;
        end
      end else if (pend) begin
        chk("burst_q", x, $signed(e[DW-1:0]));
        pend = 1'b0;
      end
    end
    chk("burst_accepted", acc, 6);
    chk("burst_drained", exp_q.size(), 0);
    chk("burst_count", cnt, 0);

    // Enable low with 3 pairs buffered: zeros and no underruns, then the 3 pairs in order.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1111 * k, -2222 * k);
      chk("hold_push_ready", sif.in_ready, 1);
      exp_q.push_back({sif.in_i, sif.in_q});
      step();
    end
    drive(1'b0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("hold_x", x, 0);
      chk("hold_underrun", und, 0);
      chk("hold_count", cnt, 0);
    end
    drain("reenable");
    chk("reenable_count", cnt, 0);

    // Reset between the I and Q halves of a pair.
    do_reset();
    en = 1'b1;
    drive(1'b1, 3000, -3000);
    step();
    drive(1'b1, 4000, -4000);
    step();
    drive(1'b0, 0, 0);
    step();
    chk("mid_rst_pre_iq", iq, 1);
    chk("mid_rst_pre_x", x, 3000);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_x", x, 0);
    chk("mid_rst_ready", sif.in_ready, 1);
    chk("mid_rst_iq", iq, 0);
    chk("mid_rst_count", cnt, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    drive(1'b1, 5000, -5000);
    exp_q.push_back({sif.in_i, sif.in_q});
    step();
    drive(1'b0, 0, 0);
    chk("post_rst_iq", iq, 1);
    chk("post_rst_x", x, 0);
    chk("post_rst_underrun", und, 1);
    step();
    chk("post_rst_no_partial_q", x, 0);
    drain("post_rst");
    chk("post_rst_count", cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_interleave.md
IQ_INTERLEAVE -- requirements
Module: iq_interleave

Interface
REQ-001 SHALL have parameter DW, default 18, sample width of each I and Q word (signed).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO depth in complex pairs, a power of 2 and at least 2.
REQ-003 SHALL have parameter CW, default 16, underrun counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  input  1  stream gate; 0 forces zero output pairs.
REQ-007 SHALL have port in_i  input  DW  signed real part of the offered pair.
REQ-008 SHALL have port in_q  input  DW  signed imaginary part of the offered pair.
REQ-009 SHALL have port in_valid  input  1  pair offered.
REQ-010 SHALL have port in_ready  output  1  pair accepted when in_valid and in_ready are both high on a clock edge.
REQ-011 SHALL have port iq  output  1  interleave phase flag, drives the downstream iq input of lp1-style filters.
REQ-012 SHALL have port x  output  DW  signed interleaved sample stream.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse on a missed pair.
REQ-014 SHALL have port underrun_count  output  CW  saturating count of underruns.

Function
REQ-015 SHALL toggle iq on every clock edge, free-running, independent of enable and FIFO state.
REQ-016 SHALL treat each edge where the pre-edge iq is 0 as a pair start, and SHALL load the real part into x at that edge.
REQ-017 SHALL load the matching imaginary part into x on the following edge, where the pre-edge iq is 1.
REQ-018 SHALL therefore present the real part on x while iq=1 and the imaginary part while iq=0, so a consumer that samples x one cycle delayed together with x at iq=0 recovers (I,Q).
REQ-019 SHALL hold the imaginary part in a holding register captured at pair start, so the FIFO is popped exactly once per pair.
REQ-020 SHALL buffer accepted pairs in a DEPTH-entry FIFO, and in_ready SHALL equal "FIFO not full", decoded from registered occupancy only.
REQ-021 SHALL refuse a push when full even if a pop occurs on the same edge; when not full, a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 SHALL pop the head at pair start when enable=1 and the FIFO is non-empty; the popped pair SHALL appear on x as I then Q.
REQ-023 SHALL, at pair start with enable=1 and the FIFO empty, emit a 0,0 pair, pulse underrun for exactly the one cycle following that edge, and increment underrun_count, saturating at 2^CW-1.
REQ-024 SHALL, at pair start with enable=0, emit a 0,0 pair with no pop and no underrun; pushes SHALL still be accepted.
REQ-025 SHALL sample enable only at pair start; a change in the middle of a pair SHALL NOT corrupt the Q half.
REQ-026 SHALL NOT see a pair pushed on a pair-start edge into an empty FIFO at that edge; it SHALL pop at the next pair start, 2 cycles later.
REQ-027 SHALL use a minimum latency of 2 edges from an accepting edge to I on x (push at an iq=1 pre-edge, pop at the next edge).

Reset
REQ-028 SHALL, while rst is high, clear iq=0, x=0, holding register=0, FIFO empty (in_ready=1), underrun=0, underrun_count=0.
REQ-029 SHALL make the first edge after rst deassertion a pair start.
REQ-030 SHALL discard FIFO contents on a reset asserted mid-pair, with no partial Q emitted after release.

Structure
REQ-031 SHALL take DW, DEPTH, CW defaults and the (I,Q) pair packing order (I in the upper DW bits) from the shared iq_stream package, reused by the matching deinterleaver.
REQ-032 SHALL place the FIFO in one sub-module, iq_pair_fifo (2*DW-bit words, push/pop/full/empty, async active-high reset).

Verification
REQ-033 SHALL verify: reset, enable=1, in_valid=0 -> x stays 0, underrun pulses every 2 cycles, count reaches 10 after 20 cycles.
REQ-034 SHALL verify: push one pair (20000,0) -> x shows 20000 with iq=1, then 0 with iq=0; feeding lp1 with kx=71000, ky=-70000 settles y_i toward its DC gain.
REQ-035 SHALL verify: burst of 6 pairs (n*1000,-n*1000) with continuous in_valid -> in_ready drops after 4 are buffered, and all 6 appear in order with no gaps or duplicates.
REQ-036 SHALL verify: enable=0 with FIFO holding 3 pairs -> zero output, count unchanged; on re-enable the 3 pairs emit in order.
REQ-037 SHALL verify: CW=4 with a starved input for 40 cycles -> count saturates at 15.
REQ-038 SHALL verify: rst asserted between the I and Q halves -> x=0 immediately, in_ready=1, and the first post-reset pair is from new input only.
